shift_ctrl: RTL

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/shift_ctrl.sv
// Sequencer for a registered 16-bit shifter: load a word, step it cnt times, then capture the result.
// Optional macro SHIFT_CTRL_CARRYCHAIN_EN: carry ops feed sh_cout back as cin after the first step.
module shift_ctrl #(
    parameter logic [2:0] HOLD_CODE = 3'd7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_cnt,
    input  logic [15:0] cmd_data,
    input  logic        cmd_cin,
    output logic [2:0]  shift,
    output logic        cin,
    output logic [15:0] indata,
    input  logic [15:0] sh_out,
    input  logic        sh_cout,
    output logic        busy,
    output logic        done,
    output logic [15:0] res_data,
    output logic        res_cout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_CAPT  = 2'd3;

    localparam logic [2:0] LOAD_CODE = 3'd4;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        cin_q, cin_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] indata_q, indata_d;
    logic [15:0] res_data_q, res_data_d;
    logic        res_cout_q, res_cout_d;
    logic        done_q, done_d;
`ifdef SHIFT_CTRL_CARRYCHAIN_EN
    logic        first_q, first_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= 2'd0;
            cin_q      <= 1'b0;
            step_q     <= 4'd0;
            indata_q   <= 16'h0000;
            res_data_q <= 16'h0000;
            res_cout_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SHIFT_CTRL_CARRYCHAIN_EN
            first_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cin_q      <= cin_d;
            step_q     <= step_d;
            indata_q   <= indata_d;
            res_data_q <= res_data_d;
            res_cout_q <= res_cout_d;
            done_q     <= done_d;
`ifdef SHIFT_CTRL_CARRYCHAIN_EN
            first_q    <= first_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cin_d      = cin_q;
        step_d     = step_q;
        indata_d   = indata_q;
        res_data_d = res_data_q;
        res_cout_d = res_cout_q;
        done_d     = 1'b0;
`ifdef SHIFT_CTRL_CARRYCHAIN_EN
        first_d    = first_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    cin_d    = cmd_cin;
                    step_d   = cmd_cnt;
                    indata_d = cmd_data;
                    state_d  = S_LOAD;
`ifdef SHIFT_CTRL_CARRYCHAIN_EN
                    first_d  = 1'b1;
`endif
                end
            end
            S_LOAD: begin
                state_d = (step_q != 4'd0) ? S_SHIFT : S_CAPT;
            end
            S_SHIFT: begin
                // step_q is never zero here: LOAD skips straight to CAPT for cnt==0
                step_d = step_q - 4'd1;
                if (step_q == 4'd1) begin
                    state_d = S_CAPT;
                end
`ifdef SHIFT_CTRL_CARRYCHAIN_EN
                first_d = 1'b0;
`endif
            end
            S_CAPT: begin
                res_data_d = sh_out;
                res_cout_d = sh_cout;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            S_LOAD:  shift = LOAD_CODE;
            S_SHIFT: shift = {1'b0, op_q};
            default: shift = HOLD_CODE;
        endcase
    end

    always_comb begin
        cin = 1'b0;
        if (state_q == S_SHIFT && op_q[0]) begin
`ifdef SHIFT_CTRL_CARRYCHAIN_EN
            // later steps chain the shifter's own carry to form a 17-bit rotate
            cin = first_q ? cin_q : sh_cout;
`else
            cin = cin_q;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign indata    = indata_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign done      = done_q;

endmodule
